// File: rtl/mic1_loader_pkg.sv
// Shared types and constants for the MIC-1 serial boot loader.
// Optional inter-byte timeout is enabled by defining MIC1_LOADER_TIMEOUT_EN.
package mic1_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StWrite,
        StCsum,
        StReply,
        StRun
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    // Inter-byte timeout, in units of one 10-bit UART frame.
    localparam int unsigned TIMEOUT_MULT = 16;

endpackage

// File: rtl/mic1_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampler, one-cycle valid/ferr pulses.
module mic1_uart_rx #(
    parameter int DIV = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e     state;
    logic          sync1, sync2, prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RxIdle;
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            prev     <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            sync1    <= ser_rx;
            sync2    <= sync1;
            prev     <= sync2;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            unique case (state)
                RxIdle: begin
                    if (prev && !sync2) begin
                        cnt   <= '0;
                        state <= RxStart;
                    end
                end
                RxStart: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        if (!sync2) begin
                            bit_idx <= '0;
                            state   <= RxData;
                        end else begin
                            state <= RxIdle;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {sync2, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RxStop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RxStop: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= RxIdle;
                        if (sync2) begin
                            rx_valid <= 1'b1;
                            rx_data  <= shreg;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/mic1_uart_loader.sv
// MIC-1 serial boot loader: framed image over UART into memory, ACK/NAK reply, CPU release.
// Define MIC1_LOADER_TIMEOUT_EN to abort stalled frames with an inter-byte timer.
module mic1_uart_loader
    import mic1_loader_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 115_200,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 12,
    parameter int LED_N  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_rx,
    output logic              ser_tx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              cpu_run,
    output logic [LED_N-1:0]  leds
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int BYTES = WORD_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TW    = $clog2(DIV);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);
    localparam logic [TW-1:0]   DIV_M1    = TW'(DIV - 1);

    loader_state_e   state;
    logic [15:0]     words_left;
    logic [BC_W-1:0] byte_cnt;
    logic [7:0]      sum;
    logic            err_csum, err_frame;
    logic            held_valid;
    logic [7:0]      held_byte;

    logic [8:0]      tx_shift;
    logic [TW-1:0]   tx_cnt;
    logic [3:0]      tx_bit;
    logic            tx_busy, tx_ack;

    logic [7:0]      rx_data;
    logic            rx_valid, rx_ferr;
    logic            in_valid;
    logic [7:0]      in_byte;

`ifdef MIC1_LOADER_TIMEOUT_EN
    localparam int TO_CYCLES = int'(TIMEOUT_MULT) * 10 * DIV;
    localparam int TO_W      = $clog2(TO_CYCLES);
    logic [TO_W-1:0] to_cnt;
`endif

    mic1_uart_rx #(
        .DIV (DIV)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .ser_rx   (ser_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    // A byte parked during WRITE takes precedence once the FSM leaves WRITE.
    always_comb begin
        in_valid = (state != StWrite) && (held_valid || rx_valid);
        in_byte  = held_valid ? held_byte : rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StIdle;
            words_left <= '0;
            byte_cnt   <= '0;
            sum        <= '0;
            err_csum   <= 1'b0;
            err_frame  <= 1'b0;
            held_valid <= 1'b0;
            held_byte  <= '0;
            tx_shift   <= '1;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_busy    <= 1'b0;
            tx_ack     <= 1'b0;
            ser_tx     <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            cpu_run    <= 1'b0;
`ifdef MIC1_LOADER_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            if (rx_ferr) err_frame <= 1'b1;

            if (state == StWrite) begin
                if (rx_valid) begin
                    if (held_valid) begin
                        err_frame <= 1'b1;
                    end else begin
                        held_valid <= 1'b1;
                        held_byte  <= rx_data;
                    end
                end
            end else if (held_valid) begin
                if (rx_valid) held_byte <= rx_data;
                else          held_valid <= 1'b0;
            end

            if (tx_busy) begin
                if (tx_cnt == DIV_M1) begin
                    tx_cnt <= '0;
                    if (tx_bit == 4'd9) begin
                        tx_busy <= 1'b0;
                        ser_tx  <= 1'b1;
                    end else begin
                        ser_tx   <= tx_shift[0];
                        tx_shift <= {1'b1, tx_shift[8:1]};
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end

            unique case (state)
                StIdle: begin
                    if (in_valid && in_byte == SYNC_BYTE) begin
                        sum   <= '0;
                        state <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (in_valid) begin
                        words_left[7:0] <= in_byte;
                        state           <= StLenHi;
                    end
                end
                StLenHi: begin
                    if (in_valid) begin
                        words_left[15:8] <= in_byte;
                        if ({in_byte, words_left[7:0]} == 16'd0) begin
                            state <= StCsum;
                        end else begin
                            mem_addr <= '0;
                            byte_cnt <= '0;
                            state    <= StData;
                        end
                    end
                end
                StData: begin
                    if (in_valid) begin
                        mem_wdata <= {in_byte, mem_wdata[WORD_W-1:8]};
                        sum       <= sum + in_byte;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            mem_we   <= 1'b1;
                            state    <= StWrite;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (mem_ready) begin
                        mem_we     <= 1'b0;
                        mem_addr   <= mem_addr + 1'b1;
                        words_left <= words_left - 16'd1;
                        state      <= (words_left == 16'd1) ? StCsum : StData;
                    end
                end
                StCsum: begin
                    if (in_valid) begin
                        ser_tx   <= 1'b0;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_busy  <= 1'b1;
                        tx_ack   <= (in_byte == sum);
                        tx_shift <= {1'b1, (in_byte == sum) ? ACK_BYTE : NAK_BYTE};
                        if (in_byte != sum) err_csum <= 1'b1;
                        state <= StReply;
                    end
                end
                StReply: begin
                    if (!tx_busy) begin
                        cpu_run <= tx_ack;
                        state   <= tx_ack ? StRun : StIdle;
                    end
                end
                StRun: cpu_run <= 1'b1;
                default: state <= StIdle;
            endcase

`ifdef MIC1_LOADER_TIMEOUT_EN
            if (state inside {StLenLo, StLenHi, StData, StCsum}) begin
                if (in_valid) begin
                    to_cnt <= '0;
                end else if (to_cnt == TO_W'(TO_CYCLES - 1)) begin
                    to_cnt    <= '0;
                    err_frame <= 1'b1;
                    state     <= StIdle;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else if (state != StWrite) begin
                to_cnt <= '0;
            end
`endif
        end
    end

    logic [4:0]       status;
    logic [LED_N+4:0] status_ext;

    always_comb begin
        status     = {err_frame, err_csum, cpu_run,
                      (state != StIdle) && (state != StRun), (state == StIdle)};
        status_ext = {{LED_N{1'b0}}, status};
        leds       = status_ext[LED_N-1:0];
    end

endmodule
